// File: rtl/reaction_timer.sv
// Reaction timer: random start delay from an LFSR, then ms-resolution reaction count with best-score tracking.
// Latency: delay_done rises CLK_DIV*target clks after DELAY entry; result_valid pulses the clk after stop/saturation.
// Backpressure: none; stop/clr_hi are single-cycle pulses, delay_en is a level. Optional BCD output via `define REACT_BCD_EN.
module reaction_timer #(
  parameter int CLK_DIV      = 25000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        delay_en,
  input  logic        stop,
  input  logic        clr_hi,
  output logic        delay_done,
  output logic        result_valid,
  output logic [13:0] reaction_ms,
  output logic [13:0] hi_score,
  output logic        new_hi,
  output logic        early,
  output logic [15:0] react_bcd
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [13:0]   MAXV       = 14'(MAX_MS);

  typedef enum logic [1:0] {IDLE, DELAY, TIMING, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   cnt_q, cnt_d;
  logic [11:0]   tgt_q, tgt_d;
  logic [13:0]   reaction_q, reaction_d;
  logic [13:0]   hi_q, hi_d;
  logic          new_hi_q, new_hi_d;
  logic          early_q, early_d;

  logic          running;
  logic          tick;
  logic [13:0]   cnt_inc;
  logic [13:0]   cnt_tim;
  logic          better;

  assign running = (state_q == DELAY) || (state_q == TIMING);
  assign tick    = running && (presc_q == PRESC_LAST);
  assign cnt_inc = cnt_q + 14'd1;
  // Count value after this cycle's tick (if any), saturated; stop captures this value.
  assign cnt_tim = tick ? ((cnt_inc >= MAXV) ? MAXV : cnt_inc) : cnt_q;

`ifdef REACT_BCD_EN
  logic [15:0] bcd_cnt_q, bcd_cnt_d;
  logic [15:0] bcd_out_q, bcd_out_d;
  logic [15:0] bcd_tim;

  function automatic logic [15:0] bcd_inc(input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    r = b;
    c = 1'b1;
    if (b != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign bcd_tim = tick ? bcd_inc(bcd_cnt_q) : bcd_cnt_q;
`endif

  // Next-state and datapath: FSM transitions, prescaler, counters, result capture.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    presc_d    = '0;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    reaction_d = reaction_q;
    hi_d       = hi_q;
    new_hi_d   = new_hi_q;
    early_d    = early_q;
    better     = 1'b0;
`ifdef REACT_BCD_EN
    bcd_cnt_d  = bcd_cnt_q;
    bcd_out_d  = bcd_out_q;
`endif
    if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (delay_en) begin
          tgt_d   = 12'(MIN_DELAY_MS) + {1'b0, lfsr_q[10:0]};
          cnt_d   = '0;
          presc_d = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (stop) begin
          // False start wins even over the terminal tick.
          state_d    = DONE;
          reaction_d = MAXV;
          early_d    = 1'b1;
          new_hi_d   = 1'b0;
`ifdef REACT_BCD_EN
          bcd_out_d  = 16'h9999;
`endif
        end else if (!delay_en) begin
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_inc == {2'b00, tgt_q}) begin
            state_d   = TIMING;
            cnt_d     = '0;
            presc_d   = '0;
`ifdef REACT_BCD_EN
            bcd_cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      TIMING: begin
        cnt_d = cnt_tim;
`ifdef REACT_BCD_EN
        bcd_cnt_d = bcd_tim;
`endif
        if (stop || (cnt_tim == MAXV)) begin
          state_d    = DONE;
          reaction_d = cnt_tim;
          early_d    = 1'b0;
          better     = (cnt_tim != MAXV) && (cnt_tim < hi_q);
          new_hi_d   = better && !clr_hi;
          if (better) begin
            hi_d = cnt_tim;
          end
`ifdef REACT_BCD_EN
          bcd_out_d  = (cnt_tim == MAXV) ? 16'h9999 : bcd_tim;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clearing the best score overrides any update in the same cycle.
    if (clr_hi) begin
      hi_d = MAXV;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= 16'hACE1;
      presc_q    <= '0;
      cnt_q      <= '0;
      tgt_q      <= '0;
      reaction_q <= '0;
      hi_q       <= MAXV;
      new_hi_q   <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      reaction_q <= reaction_d;
      hi_q       <= hi_d;
      new_hi_q   <= new_hi_d;
      early_q    <= early_d;
    end
  end

`ifdef REACT_BCD_EN
  // BCD counter and captured BCD result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_cnt_q <= '0;
      bcd_out_q <= '0;
    end else begin
      bcd_cnt_q <= bcd_cnt_d;
      bcd_out_q <= bcd_out_d;
    end
  end

  assign react_bcd = bcd_out_q;
`else
  assign react_bcd = 16'h0000;
`endif

  assign delay_done   = (state_q == TIMING);
  assign result_valid = (state_q == DONE);
  assign reaction_ms  = reaction_q;
  assign hi_score     = hi_q;
  assign new_hi       = new_hi_q;
  assign early        = early_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: round-level model of delays, captures and best score, checked every cycle.
module tb_reaction_timer;
  localparam int CLK_DIV = 4;
  localparam int MIN_D   = 10;
  localparam int MAXMS   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        delay_en = 1'b0;
  logic        stop = 1'b0;
  logic        clr_hi = 1'b0;
  logic        delay_done, result_valid, new_hi, early;
  logic [13:0] reaction_ms, hi_score;
  logic [15:0] react_bcd;

  reaction_timer #(.CLK_DIV(CLK_DIV), .MIN_DELAY_MS(MIN_D), .MAX_MS(MAXMS)) dut (
    .clk(clk), .rst_n(rst_n), .delay_en(delay_en), .stop(stop), .clr_hi(clr_hi),
    .delay_done(delay_done), .result_valid(result_valid), .reaction_ms(reaction_ms),
    .hi_score(hi_score), .new_hi(new_hi), .early(early), .react_bcd(react_bcd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected outputs, maintained by the stimulus at round granularity.
  logic        exp_dd = 1'b0, exp_rv = 1'b0, exp_nh = 1'b0, exp_early = 1'b0;
  logic [13:0] exp_rms = 14'd0;
  logic [13:0] exp_hi  = 14'(MAXMS);
  logic [15:0] exp_bcd = 16'h0000;

  // Reference LFSR: arithmetic form of the x^16+x^14+x^13+x^11 Fibonacci register.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int b;
    b = int'((v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1);
    return (v >> 1) | 16'(b << 15);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    total = total + 1;
    if ({delay_done, result_valid, reaction_ms, hi_score, new_hi, early, react_bcd} !==
        {exp_dd, exp_rv, exp_rms, exp_hi, exp_nh, exp_early, exp_bcd}) begin
      bad = bad + 1;
      $display("FAIL cycle_outputs t=%0t got dd=%b rv=%b ms=%0d hi=%0d nh=%b early=%b bcd=%h want dd=%b rv=%b ms=%0d hi=%0d nh=%b early=%b bcd=%h",
               $time, delay_done, result_valid, reaction_ms, hi_score, new_hi, early, react_bcd,
               exp_dd, exp_rv, exp_rms, exp_hi, exp_nh, exp_early, exp_bcd);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A result appears: apply the scoring rules to the model.
  task automatic post_result(input int cap, input bit is_early);
    bit sat;
    sat       = is_early || (cap >= MAXMS);
    exp_dd    = 1'b0;
    exp_rv    = 1'b1;
    exp_early = is_early;
    exp_rms   = sat ? 14'(MAXMS) : 14'(cap);
    if (!sat && cap < int'(exp_hi)) begin
      exp_hi = 14'(cap);
      exp_nh = 1'b1;
    end else begin
      exp_nh = 1'b0;
    end
`ifdef REACT_BCD_EN
    exp_bcd = sat ? 16'h9999 : to_bcd(cap);
`else
    exp_bcd = 16'h0000;
`endif
  endtask

  task automatic end_done();
    step();
    exp_rv = 1'b0;
  endtask

  // Request a delay from IDLE; returns the target in ms. Ends just after the DELAY entry edge.
  task automatic start_delay(output int t);
    delay_en = 1'b1;
    t = MIN_D + int'(m_lfsr & 16'h07FF);
    step();
  endtask

  // Full round: wait out the delay, then stop s clks into TIMING (or let it saturate).
  task automatic do_timing(input int s, input bit do_stop);
    int t;
    start_delay(t);
    repeat (4 * t - 1) step();
    step();
    exp_dd = 1'b1;
    delay_en = 1'($urandom_range(0, 1));
    for (int i = 1; i < s; i++) step();
    stop = do_stop;
    delay_en = 1'b0;
    step();
    stop = 1'b0;
    post_result(s / CLK_DIV, 1'b0);
  endtask

  task automatic do_early(input bit terminal);
    int t, m;
    start_delay(t);
    m = terminal ? 4 * t : $urandom_range(1, 39);
    for (int i = 1; i < m; i++) step();
    stop = 1'b1;
    delay_en = 1'b0;
    step();
    stop = 1'b0;
    post_result(0, 1'b1);
  endtask

  task automatic do_abort();
    int t, m;
    start_delay(t);
    m = $urandom_range(1, 39);
    for (int i = 1; i < m; i++) step();
    delay_en = 1'b0;
    step();
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      stop = 1'($urandom_range(0, 1));
      step();
      stop = 1'b0;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("reset_reaction_ms", 16'(reaction_ms), 16'd0);
    check("reset_hi_score", 16'(hi_score), 16'd50);
    check("reset_flags", {12'd0, delay_done, result_valid, new_hi, early}, 16'd0);
    rst_n = 1'b1;
    step();
    check("model_lfsr_first_step", m_lfsr, 16'h5670);

    // Stop 28 clks into TIMING: 7 ticks.
    do_timing(28, 1'b1);
    check("r1_reaction_ms", 16'(reaction_ms), 16'd7);
    check("r1_hi_score", 16'(hi_score), 16'd7);
    check("r1_new_hi", 16'(new_hi), 16'd1);
    check("r1_result_valid", 16'(result_valid), 16'd1);
`ifdef REACT_BCD_EN
    check("r1_react_bcd", react_bcd, 16'h0007);
`else
    check("r1_react_bcd", react_bcd, 16'h0000);
`endif
    end_done();
    idle_gap(4);

    // Stop 38 clks in: 9 ticks, not an improvement.
    do_timing(38, 1'b1);
    check("r2_reaction_ms", 16'(reaction_ms), 16'd9);
    check("r2_hi_score", 16'(hi_score), 16'd7);
    check("r2_new_hi", 16'(new_hi), 16'd0);
    end_done();
    idle_gap(3);

    do_early(1'b0);
    check("early_flag", 16'(early), 16'd1);
    check("early_reaction_ms", 16'(reaction_ms), 16'd50);
    check("early_hi_score", 16'(hi_score), 16'd7);
    end_done();
    idle_gap(2);

    do_abort();
    check("abort_no_valid", {14'd0, result_valid, delay_done}, 16'd0);
    check("abort_reaction_kept", 16'(reaction_ms), 16'd50);
    idle_gap(3);

    // No stop: saturates after 200 clks.
    do_timing(4 * MAXMS, 1'b0);
    check("timeout_reaction_ms", 16'(reaction_ms), 16'd50);
    check("timeout_hi_score", 16'(hi_score), 16'd7);
    check("timeout_early", 16'(early), 16'd0);
    end_done();

    clr_hi = 1'b1;
    step();
    clr_hi = 1'b0;
    exp_hi = 14'(MAXMS);
    check("clr_hi_score", 16'(hi_score), 16'd50);
    idle_gap(2);

    for (int r = 0; r < 4; r++) begin
      case ($urandom_range(0, 3))
        0: begin do_timing($urandom_range(1, 4 * MAXMS), 1'b1); end_done(); end
        1: begin do_early($urandom_range(0, 1) == 1); end_done(); end
        2: do_abort();
        default: begin do_timing(4 * MAXMS, 1'b0); end_done(); end
      endcase
      idle_gap($urandom_range(1, 6));
    end

    // Reset in the middle of TIMING discards the measurement.
    begin
      int t;
      start_delay(t);
      repeat (4 * t) step();
      exp_dd = 1'b1;
      repeat (13) step();
      rst_n = 1'b0;
      delay_en = 1'b0;
      exp_dd = 1'b0; exp_rv = 1'b0; exp_rms = 14'd0; exp_hi = 14'(MAXMS);
      exp_nh = 1'b0; exp_early = 1'b0; exp_bcd = 16'h0000;
      #1;
      check("midreset_flags", {12'd0, delay_done, result_valid, new_hi, early}, 16'd0);
      check("midreset_reaction_ms", 16'(reaction_ms), 16'd0);
      check("midreset_hi_score", 16'(hi_score), 16'd50);
      check("midreset_bcd", react_bcd, 16'h0000);
      step();
      step();
      rst_n = 1'b1;
      idle_gap(4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25000, clk cycles per ms tick (50 MHz/2 = 25 MHz domain clock).
REQ-002 SHALL have parameter MIN_DELAY_MS, default 1000, fixed part of the random delay in ms.
REQ-003 SHALL have parameter MAX_MS, default 9999, saturation value of the reaction count.
REQ-004 SHALL have port clk, input, 1, sole clock, all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port delay_en, input, 1, level from game controller requesting the random delay (high only while controller is in DELAYING).
REQ-007 SHALL have port stop, input, 1, single-cycle synchronized key-press pulse.
REQ-008 SHALL have port clr_hi, input, 1, single-cycle pulse restoring hi_score to MAX_MS.
REQ-009 SHALL have port delay_done, output, 1, level high while in TIMING (controller's ready input).
REQ-010 SHALL have port result_valid, output, 1, one-cycle pulse when reaction_ms/early update.
REQ-011 SHALL have port reaction_ms, output, 14, last captured reaction time in ms.
REQ-012 SHALL have port hi_score, output, 14, best (lowest) valid reaction time.
REQ-013 SHALL have port new_hi, output, 1, high from a result that improved hi_score until next result_valid.
REQ-014 SHALL have port early, output, 1, last result was a false start.
REQ-015 SHALL have port react_bcd, output, 16, four BCD digits of reaction_ms (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, DELAY, TIMING, DONE.
REQ-017 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advancing every clk in all states; never all-zero.
REQ-018 SHALL, in IDLE with delay_en=1, latch target = MIN_DELAY_MS + lfsr[10:0] (12-bit, 1000..3047 at default), clear ms count and prescaler, go DELAY next clk.
REQ-019 SHALL generate ms tick when prescaler reaches CLK_DIV-1; prescaler wraps to 0 and is cleared on entry to DELAY and TIMING, so first tick is exactly CLK_DIV clks after entry.
REQ-020 SHALL, in DELAY, increment ms count per tick; on tick making count == target go TIMING with ms count cleared.
REQ-021 SHALL, in DELAY, on delay_en=0 before target abort to IDLE with no result_valid and outputs unchanged.
REQ-022 SHALL, in DELAY, on stop=1 (including same cycle as terminal tick) go DONE with early=1, reaction_ms=MAX_MS, hi_score unchanged.
REQ-023 SHALL ignore delay_en in TIMING and DONE.
REQ-024 SHALL, in TIMING, increment ms count per tick, saturating at MAX_MS; stop captures count into reaction_ms (a tick in the same cycle counts first), early=0, go DONE.
REQ-025 SHALL, in TIMING, on reaching MAX_MS without stop go DONE with reaction_ms=MAX_MS, early=0, hi_score not updated.
REQ-026 SHALL, on a valid non-saturated capture strictly below hi_score, load hi_score and set new_hi=1; otherwise new_hi=0.
REQ-027 SHALL hold DONE exactly one clk, asserting result_valid, then return to IDLE.
REQ-028 SHALL give clr_hi priority over a same-cycle hi_score update.
REQ-029 SHALL ignore stop in IDLE and DONE.

Reset
REQ-030 SHALL on rst_n=0 asynchronously force: state IDLE, LFSR 16'hACE1, prescaler 0, count 0, delay_done 0, result_valid 0, reaction_ms 0, hi_score MAX_MS, new_hi 0, early 0, react_bcd 0.
REQ-031 SHALL treat reset mid-DELAY/TIMING as discarding the measurement with no result_valid.

Configuration
REQ-032 SHALL, with REACT_BCD_EN defined, maintain a 4-digit BCD counter in lockstep with the TIMING ms count (same clear, increment, saturation at 9999) and load react_bcd alongside reaction_ms (9999 BCD on early/saturation).
REQ-033 SHALL, without REACT_BCD_EN, omit the BCD counter and tie react_bcd to 16'h0000; all other behaviour identical.

Verification (CLK_DIV=4, MIN_DELAY_MS=10, MAX_MS=50)
REQ-034 SHALL cover: reset, delay_en=1 -> delay_done rises exactly 4*(10+lfsr[10:0] at latch) clks after DELAY entry.
REQ-035 SHALL cover: stop after 7 ticks in TIMING -> result_valid pulse, reaction_ms=7, hi_score=7, new_hi=1, react_bcd=16'h0007 with REACT_BCD_EN.
REQ-036 SHALL cover: second round with stop at 9 ticks -> reaction_ms=9, hi_score=7, new_hi=0.
REQ-037 SHALL cover: stop during DELAY -> early=1, reaction_ms=50, hi_score unchanged; delay_en dropped in DELAY -> IDLE, no result_valid.
REQ-038 SHALL cover: no stop in TIMING -> reaction_ms=50 after 200 clks, hi_score unchanged; clr_hi -> hi_score=50.
REQ-039 SHALL cover: rst_n low mid-TIMING -> all outputs at REQ-030 values immediately, no result_valid.
